// File: rtl/alu_pkg.sv
// Shared widths and opcode encoding for the 8-bit ALU.
// Imported by the combinational core and the registered wrapper.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_SLT = 4'd8,
    OP_EQ  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational ALU datapath: result plus Z/N/C/V flags.
// Opcodes 10..15 produce a zero result with clear C/V.
module alu_8bit_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [SEL_W-1:0]  ALU_Sel,
  output logic [RES_W-1:0]  Y,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [RES_W-1:0]  w_prod;
  logic              w_lt;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_prod = {8'h00, A} * {8'h00, B};
  assign w_lt   = $signed(A) < $signed(B);

  always_comb begin
    Y = '0;
    C = 1'b0;
    V = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        Y = {8'h00, w_sum[7:0]};
        C = w_sum[8];
        V = ~(A[7] ^ B[7]) & (A[7] ^ w_sum[7]);
      end
      OP_SUB: begin
        Y = {8'h00, w_diff[7:0]};
        C = w_diff[8];
        V = (A[7] ^ B[7]) & (A[7] ^ w_diff[7]);
      end
      OP_AND: Y = {8'h00, A & B};
      OP_OR:  Y = {8'h00, A | B};
      OP_XOR: Y = {8'h00, A ^ B};
      OP_SHL: Y = {8'h00, A[6:0], 1'b0};
      OP_SHR: Y = {8'h00, 1'b0, A[7:1]};
      OP_MUL: Y = w_prod;
      OP_SLT: Y = {15'd0, w_lt};
      OP_EQ:  Y = {15'd0, A == B};
      default: Y = '0;
    endcase
  end

  // N follows the 16-bit result, so only MUL can set it
  assign Z = (Y == '0);
  assign N = Y[RES_W-1];

endmodule

// File: rtl/alu_8bit.sv
// 8-bit ALU execute unit: combinational core plus one output register.
// Results and flags appear one clock after operands are applied.
module alu_8bit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [SEL_W-1:0]  ALU_Sel,
  output logic [RES_W-1:0]  Y,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  logic [RES_W-1:0] w_y;
  logic             w_z;
  logic             w_n;
  logic             w_c;
  logic             w_v;

  logic [RES_W-1:0] r_y;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  alu_8bit_core u_core (
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .Y       (w_y),
    .Z       (w_z),
    .N       (w_n),
    .C       (w_c),
    .V       (w_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= '0;
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_y <= w_y;
      r_z <= w_z;
      r_n <= w_n;
      r_c <= w_c;
      r_v <= w_v;
    end
  end

  assign Y = r_y;
  assign Z = r_z;
  assign N = r_n;
  assign C = r_c;
  assign V = r_v;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed plan vectors plus
// a pipelined random stream checked against an integer model.
module tb_alu_8bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_Sel;
  logic [15:0] Y;
  logic        Z, N, C, V;

  int n_chk  = 0;
  int n_fail = 0;

  alu_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .Y       (Y),
    .Z       (Z),
    .N       (N),
    .C       (C),
    .V       (V)
  );

  always #5 clk = ~clk;

  // Expected {Y, Z, N, C, V} from the opcode table, plain integers.
  function automatic logic [19:0] model(int a, int b, int sel);
    int y, c, v, sa, sb, d;
    c = 0;
    v = 0;
    case (sel)
      0: begin
        y = (a + b) % 256;
        c = (a + b > 255);
        v = ((a >= 128) == (b >= 128)) && ((a >= 128) != (y >= 128));
      end
      1: begin
        d = a - b;
        y = (d + 256) % 256;
        c = (a < b);
        v = ((a >= 128) != (b >= 128)) && ((a >= 128) != (y >= 128));
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (a * 2) % 256;
      6: y = a / 2;
      7: y = a * b;
      8: begin
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        y = (sa < sb);
      end
      9: y = (a == b);
      default: y = 0;
    endcase
    return {y[15:0], y == 0, y >= 32768, c[0], v[0]};
  endfunction

  task automatic chk(string tag, logic [19:0] got, logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got Y=%h ZNCV=%b, expected Y=%h ZNCV=%b",
               tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic run_op(string tag, int a, int b, int sel,
                        logic [19:0] exp);
    @(negedge clk);
    A = a[7:0];
    B = b[7:0];
    ALU_Sel = sel[3:0];
    @(negedge clk);
    chk(tag, {Y, Z, N, C, V}, exp);
    chk({tag, "_model"}, {Y, Z, N, C, V}, model(a, b, sel));
  endtask

  logic [19:0] pend;
  bit          have_pend;
  int          ra, rb, rs;

  initial begin
    rst = 1'b1;
    A = 8'd0;
    B = 8'd0;
    ALU_Sel = 4'd0;
    #12;
    chk("reset_init", {Y, Z, N, C, V}, 20'h0);

    @(negedge clk);
    rst = 1'b0;
    A = 8'd255;
    B = 8'd255;
    ALU_Sel = 4'd7;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", {Y, Z, N, C, V}, 20'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", {Y, Z, N, C, V}, 20'h0);

    @(negedge clk);
    A = 8'd0;
    B = 8'd0;
    ALU_Sel = 4'd0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_first", {Y, Z, N, C, V}, {16'h0000, 4'b1000});

    run_op("add_v",   51,  77,  0, {16'h0080, 4'b0001});
    run_op("add_cv",  204, 154, 0, {16'h0066, 4'b0011});
    run_op("sub_brw", 0,   77,  1, {16'h00B3, 4'b0010});
    run_op("mul_max", 255, 255, 7, {16'hFE01, 4'b0100});
    run_op("slt_t",   204, 77,  8, {16'h0001, 4'b0000});
    run_op("slt_f",   255, 154, 8, {16'h0000, 4'b1000});
    run_op("eq_zero", 0,   0,   9, {16'h0001, 4'b0000});
    run_op("and",     255, 154, 2, {16'h009A, 4'b0000});
    run_op("or",      255, 154, 3, {16'h00FF, 4'b0000});
    run_op("xor",     255, 154, 4, {16'h0065, 4'b0000});
    run_op("shl",     255, 154, 5, {16'h00FE, 4'b0000});
    run_op("shr",     255, 154, 6, {16'h007F, 4'b0000});
    run_op("undef_f", 255, 154, 15, {16'h0000, 4'b1000});
    run_op("undef_a", 17,  3,   10, {16'h0000, 4'b1000});

    // New operation every cycle; each result must land exactly one edge later.
    have_pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (have_pend)
        chk("b2b", {Y, Z, N, C, V}, pend);
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 15));
      if (i % 16 == 0) rb = ra;
      if (i % 23 == 0) ra = 0;
      A = ra[7:0];
      B = rb[7:0];
      ALU_Sel = rs[3:0];
      pend = model(ra, rb, rs);
      have_pend = 1'b1;
    end
    @(negedge clk);
    chk("b2b_last", {Y, Z, N, C, V}, pend);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit integer ALU with a 4-bit opcode, a 16-bit result and Z/N/C/V status flags.
- A combinational datapath computes the result and flags; one register stage presents them.
- Result and flags are valid 1 clock after the operands and opcode are applied.
- Used as the arithmetic/logic execute unit of the datapath.

Parameters:
- none. Widths are fixed: operands 8, opcode 4, result 16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  8  operand A (unsigned; also read as two's-complement for SLT and V)
- B  input  8  operand B
- ALU_Sel  input  4  opcode
- Y  output  16  registered result
- Z  output  1  registered zero flag
- N  output  1  registered negative flag
- C  output  1  registered carry/borrow flag
- V  output  1  registered signed-overflow flag

Behaviour:
- Reset (async, rst=1): Y=0, Z=0, N=0, C=0, V=0 immediately. They hold while rst=1. The first capture happens on the first rising clk after rst deasserts.
- Every rising clk (rst=0): register the combinational result of the current A, B, ALU_Sel. Latency is exactly 1 cycle. There is no handshake and a new operation is accepted every cycle.
- Opcodes (result zero-extended to 16 bits unless noted):
  - 0000 ADD: Y = (A+B) mod 256
  - 0001 SUB: Y = (A−B) mod 256
  - 0010 AND: Y = A&B
  - 0011 OR: Y = A|B
  - 0100 XOR: Y = A^B
  - 0101 SHL: Y = (A<<1) mod 256; 0 shifted in, MSB discarded
  - 0110 SHR: Y = A>>1, logical, 0 shifted into bit 7
  - 0111 MUL: Y = A*B, unsigned, full 16 bits
  - 1000 SLT: Y = 1 if signed(A) < signed(B), else 0
  - 1001 EQ: Y = 1 if A==B, else 0
  - 1010–1111: Y = 0
- Z = (Y == 16'h0000), for all opcodes including the undefined ones (so Z=1 there).
- N = Y[15]. It can only be 1 for MUL; it is not bit 7 of 8-bit results.
- C:
  - ADD: bit 8 of the 9-bit sum {0,A}+{0,B}
  - SUB: bit 8 of the 9-bit {0,A}−{0,B}, i.e. borrow, 1 when A<B unsigned
  - all other opcodes: 0
- V:
  - ADD: ~(A7^B7) & (A7^Y7)
  - SUB: (A7^B7) & (A7^Y7)
  - all other opcodes: 0
- No X propagation from valid inputs; all outputs are fully driven every cycle.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams/enum: OP_ADD..OP_EQ = 0..9
  - width constants: DATA_W=8, RES_W=16, SEL_W=4
- Sub-module alu_8bit_core: purely combinational (A, B, ALU_Sel → Y, Z, N, C, V).
- alu_8bit wraps alu_8bit_core with the async-reset output register.

Test Plan:
- Reset: assert rst mid-operation → all outputs 0 immediately. After release, A=0, B=0, Sel=0000 → next cycle Y=0, Z=1, C=0, V=0.
- ADD:
  - A=51, B=77 → Y=0x0080, C=0, V=1, N=0, Z=0.
  - A=204, B=154 → Y=0x0066, C=1, V=1.
- SUB: A=0, B=77 → Y=0x00B3, C=1, V=0, Z=0.
- MUL: A=255, B=255 → Y=0xFE01, N=1, Z=0, C=0, V=0.
- SLT/EQ:
  - SLT A=204, B=77 → Y=1.
  - SLT A=255, B=154 → Y=0.
  - EQ A=B=0 → Y=1, Z=0.
- Logic/shift/undefined:
  - A=255, B=154: AND=0x9A, OR=0xFF, XOR=0x65, SHL=0xFE, SHR=0x7F.
  - Sel=1111 → Y=0, Z=1, C=V=0.
  - Back-to-back opcode changes each cycle → each result appears exactly 1 cycle later.
